// File: rtl/rename_walk_unit_pkg.sv
// rename_walk_unit_pkg: shared constants, walk FSM states and sequence-age helper for the rename core
package rename_walk_unit_pkg;
  localparam int NUM_AREGS = 32;
  localparam int AREG_W = 5;
  typedef enum logic {ST_IDLE, ST_WALK} t_walk_state;
  // true when a is strictly younger than b under bits-wide modular sequence numbering
  function automatic logic seq_younger(input logic [31:0] a, input logic [31:0] b, input int bits);
    logic [31:0] d;
    d = (a - b) << (32 - bits);
    return !d[31] && (d != '0);
  endfunction
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free pregs with one pop and two ordered push ports
module rename_free_list #(
  parameter int p_depth = 4,
  parameter int p_width = 6,
  parameter int p_base  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pop,
  output logic [p_width-1:0] pop_data,
  input  logic               push0,
  input  logic [p_width-1:0] push0_data,
  input  logic               push1,
  input  logic [p_width-1:0] push1_data,
  output logic               full,
  output logic               empty
);
  localparam int IW = p_depth > 1 ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);
  logic [p_width-1:0] mem_q [p_depth];
  logic [IW-1:0] head_q, tail_q, tail_1, tail_d;
  logic [CW-1:0] cnt_q;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(p_depth - 1)) ? '0 : i + IW'(1);
  endfunction
  assign tail_1 = inc(tail_q);
  assign tail_d = (push0 && push1) ? inc(tail_1) : (push0 || push1) ? tail_1 : tail_q;
  assign pop_data = mem_q[head_q];
  assign full = cnt_q == CW'(p_depth);
  assign empty = cnt_q == '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < p_depth; i++) mem_q[i] <= p_width'(p_base + i);
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= CW'(p_depth);
    end else begin
      if (pop) head_q <= inc(head_q);
      if (push0) mem_q[tail_q] <= push0_data;
      if (push1) mem_q[push0 ? tail_1 : tail_q] <= push1_data;
      tail_q <= tail_d;
      cnt_q <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
endmodule

// File: rtl/rename_walk_unit.sv
// rename_walk_unit: speculative arch->phys map with free list, ready table, rename log
// and precise partial squash recovery by walking the log back from its tail.
module rename_walk_unit
  import rename_walk_unit_pkg::*;
#(
  parameter int p_num_phys_regs = 36,
  parameter int p_seq_num_bits  = 5,
  parameter int p_num_read      = 2,
  localparam int P = $clog2(p_num_phys_regs),
  localparam int S = p_seq_num_bits,
  localparam int R = p_num_read
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_val,
  output logic                alloc_rdy,
  input  logic [AREG_W-1:0]   alloc_areg,
  input  logic [S-1:0]        alloc_seq_num,
  output logic [P-1:0]        alloc_preg,
  output logic [P-1:0]        alloc_ppreg,
  input  logic [R*AREG_W-1:0] rd_areg,
  output logic [R*P-1:0]      rd_preg,
  output logic [R-1:0]        rd_pready,
  input  logic                complete_val,
  input  logic [P-1:0]        complete_preg,
  input  logic                commit_val,
  input  logic                commit_wen,
  input  logic [S-1:0]        commit_seq_num,
  input  logic                squash_val,
  input  logic [S-1:0]        squash_seq_num,
  output logic                busy
);
  localparam int F = p_num_phys_regs - NUM_AREGS;
  localparam int LW = F > 1 ? $clog2(F) : 1;
  localparam int CW = $clog2(F + 1);
  typedef struct packed {
    logic [S-1:0]      seq_num;
    logic [AREG_W-1:0] areg;
    logic [P-1:0]      preg;
    logic [P-1:0]      ppreg;
  } t_rename_log_entry;
  t_rename_log_entry log_q [F];
  t_rename_log_entry tail_ent;
  logic [LW-1:0] head_q, tail_q, tail_prev;
  logic [CW-1:0] cnt_q;
  logic [P-1:0] map_q [NUM_AREGS];
  logic [p_num_phys_regs-1:0] pready_q;
  t_walk_state state_q, state_d;
  logic [S-1:0] target_q, target_d;
  logic [P-1:0] fl_head;
  logic fl_full, fl_empty;
  logic fire, wr_fire, commit_ok, undo, log_nonempty, young_tgt, young_sq, sq_older;
  function automatic logic [LW-1:0] inc(input logic [LW-1:0] i);
    return (i == LW'(F - 1)) ? '0 : i + LW'(1);
  endfunction
  function automatic logic [LW-1:0] dec(input logic [LW-1:0] i);
    return (i == '0) ? LW'(F - 1) : i - LW'(1);
  endfunction
  assign tail_prev = dec(tail_q);
  assign tail_ent = log_q[tail_prev];
  assign log_nonempty = cnt_q != '0;
  assign busy = state_q == ST_WALK;
  assign alloc_rdy = rst && !busy && !squash_val && !fl_empty;
  assign fire = alloc_val && alloc_rdy;
  assign wr_fire = fire && alloc_areg != '0;
  assign alloc_preg = (alloc_areg == '0) ? '0 : fl_head;
  assign alloc_ppreg = map_q[alloc_areg];
  assign commit_ok = commit_val && commit_wen && log_nonempty && log_q[head_q].seq_num == commit_seq_num;
  assign young_tgt = log_nonempty && seq_younger(32'(tail_ent.seq_num), 32'(target_q), S);
  assign young_sq = log_nonempty && seq_younger(32'(tail_ent.seq_num), 32'(squash_seq_num), S);
  assign sq_older = squash_val && seq_younger(32'(target_q), 32'(squash_seq_num), S);
  // a deeper squash arriving mid-walk can keep the walk alive after the old target is reached
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    undo = 1'b0;
    if (state_q == ST_IDLE) begin
      state_d = (squash_val && young_sq) ? ST_WALK : ST_IDLE;
      target_d = (squash_val && young_sq) ? squash_seq_num : target_q;
    end else begin
      undo = young_tgt;
      target_d = sq_older ? squash_seq_num : target_q;
      state_d = (young_tgt || (sq_older && young_sq)) ? ST_WALK : ST_IDLE;
    end
  end
  always_comb begin
    rd_preg = '0;
    rd_pready = '0;
    for (int i = 0; i < R; i++) begin
      rd_preg[i*P +: P] = map_q[rd_areg[i*AREG_W +: AREG_W]];
      rd_pready[i] = pready_q[map_q[rd_areg[i*AREG_W +: AREG_W]]];
    end
  end
  rename_free_list #(.p_depth(F), .p_width(P), .p_base(NUM_AREGS)) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop        (wr_fire),
    .pop_data   (fl_head),
    .push0      (commit_ok),
    .push0_data (log_q[head_q].ppreg),
    .push1      (undo),
    .push1_data (tail_ent.preg),
    .full       (fl_full),
    .empty      (fl_empty)
  );
  // complete is applied before alloc so a same-cycle reissue of that preg stays not-ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AREGS; i++) map_q[i] <= P'(i);
      pready_q <= '1;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      state_q <= ST_IDLE;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      if (complete_val) pready_q[complete_preg] <= 1'b1;
      if (wr_fire) begin
        map_q[alloc_areg] <= fl_head;
        pready_q[fl_head] <= 1'b0;
        tail_q <= inc(tail_q);
      end
      if (undo) begin
        map_q[tail_ent.areg] <= tail_ent.ppreg;
        tail_q <= tail_prev;
      end
      if (commit_ok) head_q <= inc(head_q);
      cnt_q <= cnt_q + CW'(wr_fire) - CW'(commit_ok) - CW'(undo);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_fire) log_q[tail_q] <= '{seq_num: alloc_seq_num, areg: alloc_areg, preg: fl_head, ppreg: map_q[alloc_areg]};
  end
  assert property (@(posedge clk) disable iff (!rst)
    (commit_val && commit_wen) |-> (log_nonempty && log_q[head_q].seq_num == commit_seq_num))
    else $error("rename_walk_unit: commit_wen with empty log or seq number not at log head");
  assert property (@(posedge clk) disable iff (!rst) (commit_ok || undo) |-> !fl_full)
    else $error("rename_walk_unit: free list overflow");
endmodule
